cordic_vectoring: RTL and testbench



---
 rtl/cordic_vectoring_if.sv | 23 ++
 rtl/cordic_vectoring.sv | 187 ++++++++++++++++++
 tb/tb_cordic_vectoring.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_vectoring_if.sv
// rtl/cordic_vectoring_if.sv - start/done operand and polar-result bundle for cordic_vectoring
// master drives the operand, slave (the engine) returns busy/done and the polar result.

interface cordic_vectoring_if;
   logic               start;
   logic signed [31:0] re;
   logic signed [31:0] im;
   logic               busy;
   logic               done;
   logic [33:0]        mag;
   logic [31:0]        angle;
   logic [65:0]        polar;

   modport master (
      output start, re, im,
      input  busy, done, mag, angle, polar
   );

   modport slave (
      input  start, re, im,
      output busy, done, mag, angle, polar
   );
endinterface

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative CORDIC vectoring engine: (re, im) -> {magnitude, BAM angle}
// Optional build macro CORDIC_GAIN_COMP_EN adds a GAIN state that removes the CORDIC gain from mag.

module cordic_vectoring #(
   parameter int ITER = 30,
   parameter int AW   = 32
) (
   input  logic              clock,
   input  logic              reset,
   cordic_vectoring_if.slave bus
);
   // Eight fractional guard bits below the 34-bit integer datapath keep shift truncation out of mag.
   localparam int         GB   = 8;
   localparam int         XW   = 34 + GB;
   localparam logic [4:0] LAST = 5'(ITER - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_ROT,
      S_GAIN,
      S_DONE
   } state_t;

   state_t               state;
   logic signed [XW-1:0] x;
   logic signed [XW-1:0] y;
   logic signed [XW-1:0] x_sh;
   logic signed [XW-1:0] y_sh;
   logic [AW-1:0]        z;
   logic [4:0]           iter;
   logic                 zero_in;
   logic                 busy_q;
   logic                 done_q;
   logic [33:0]          mag_q;
   logic [33:0]          mag_val;
   logic [AW-1:0]        angle_q;
   logic [AW-1:0]        angle_val;
   logic [33+AW:0]       polar_q;

   function automatic logic [AW-1:0] atan_tab(input logic [4:0] idx);
      case (idx)
         5'd0:    atan_tab = 32'h2000_0000;
         5'd1:    atan_tab = 32'h12E4_051E;
         5'd2:    atan_tab = 32'h09FB_385B;
         5'd3:    atan_tab = 32'h0511_11D4;
         5'd4:    atan_tab = 32'h028B_0D43;
         5'd5:    atan_tab = 32'h0145_D7E1;
         5'd6:    atan_tab = 32'h00A2_F61E;
         5'd7:    atan_tab = 32'h0051_7C55;
         5'd8:    atan_tab = 32'h0028_BE53;
         5'd9:    atan_tab = 32'h0014_5F2F;
         5'd10:   atan_tab = 32'h000A_2F98;
         5'd11:   atan_tab = 32'h0005_17CC;
         5'd12:   atan_tab = 32'h0002_8BE6;
         5'd13:   atan_tab = 32'h0001_45F3;
         5'd14:   atan_tab = 32'h0000_A2FA;
         5'd15:   atan_tab = 32'h0000_517D;
         5'd16:   atan_tab = 32'h0000_28BE;
         5'd17:   atan_tab = 32'h0000_145F;
         5'd18:   atan_tab = 32'h0000_0A30;
         5'd19:   atan_tab = 32'h0000_0518;
         5'd20:   atan_tab = 32'h0000_028C;
         5'd21:   atan_tab = 32'h0000_0146;
         5'd22:   atan_tab = 32'h0000_00A3;
         5'd23:   atan_tab = 32'h0000_0051;
         5'd24:   atan_tab = 32'h0000_0029;
         5'd25:   atan_tab = 32'h0000_0014;
         5'd26:   atan_tab = 32'h0000_000A;
         5'd27:   atan_tab = 32'h0000_0005;
         5'd28:   atan_tab = 32'h0000_0003;
         5'd29:   atan_tab = 32'h0000_0001;
         5'd30:   atan_tab = 32'h0000_0001;
         default: atan_tab = '0;
      endcase
   endfunction

   assign x_sh = x >>> iter;
   assign y_sh = y >>> iter;

`ifdef CORDIC_GAIN_COMP_EN
   localparam int PW = XW + 32;
   logic [33:0] mag_gain;
   logic [33:0] mag_res;

   // K = 0x9B74EDA8 / 2^32 ~ 0.607253, rounded; the guard bits are dropped in the same shift.
   assign mag_gain = 34'((PW'($unsigned(x)) * PW'(32'h9B74_EDA8) + (PW'(1) << (31 + GB))) >> (32 + GB));
   assign mag_val  = zero_in ? '0 : mag_res;
`else
   logic [33:0] x_round;

   assign x_round = 34'(($unsigned(x) + XW'(1 << (GB - 1))) >> GB);
   assign mag_val = zero_in ? '0 : x_round;
`endif

   // A zero operand has no defined angle; force both results rather than report the iteration residue.
   assign angle_val = zero_in ? '0 : z;

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= S_IDLE;
         x       <= '0;
         y       <= '0;
         z       <= '0;
         iter    <= '0;
         zero_in <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mag_q   <= '0;
         angle_q <= '0;
         polar_q <= '0;
`ifdef CORDIC_GAIN_COMP_EN
         mag_res <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  x       <= {{2{bus.re[31]}}, bus.re, {GB{1'b0}}};
                  y       <= {{2{bus.im[31]}}, bus.im, {GB{1'b0}}};
                  zero_in <= (bus.re == '0) && (bus.im == '0);
                  state   <= S_PRE;
               end
            end
            S_PRE: begin
               busy_q <= 1'b1;
               iter   <= '0;
               state  <= S_ROT;
               // Left half-plane operands are turned by -/+90 degrees so the rotations start with x >= 0.
               if (!x[XW-1]) begin
                  z <= '0;
               end else if (!y[XW-1]) begin
                  x <= y;
                  y <= -x;
                  z <= 32'h4000_0000;
               end else begin
                  x <= -y;
                  y <= x;
                  z <= 32'hC000_0000;
               end
            end
            S_ROT: begin
               if (y[XW-1]) begin
                  x <= x - y_sh;
                  y <= y + x_sh;
                  z <= z - atan_tab(iter);
               end else begin
                  x <= x + y_sh;
                  y <= y - x_sh;
                  z <= z + atan_tab(iter);
               end
               if (iter == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
                  state <= S_GAIN;
`else
                  state <= S_DONE;
`endif
               end else begin
                  iter <= iter + 5'd1;
               end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_GAIN: begin
               mag_res <= mag_gain;
               state   <= S_DONE;
            end
`endif
            S_DONE: begin
               mag_q   <= mag_val;
               angle_q <= angle_val;
               polar_q <= {mag_val, angle_val};
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.mag   = mag_q;
   assign bus.angle = angle_q;
   assign bus.polar = polar_q;
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - self-checking bench for cordic_vectoring against a real-arithmetic polar model
// Honours CORDIC_GAIN_COMP_EN for latency and magnitude scaling.

module tb_cordic_vectoring;
   localparam int ITER = 30;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int LAT = ITER + 3;
`else
   localparam int LAT = ITER + 2;
`endif
   localparam real TWO_PI  = 6.283185307179586;
   localparam int  ANG_TOL = 64;
   localparam real MAG_TOL = 4.0;

   logic clock = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   real  mag_scale;

   always #5 clock = ~clock;

   cordic_vectoring_if bus ();

   cordic_vectoring #(.ITER(ITER), .AW(32)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   function automatic void model(input logic signed [31:0] a, input logic signed [31:0] b,
                                 output real m, output logic [31:0] ang);
      real    ra;
      real    rb;
      longint q;
      ra  = real'(a);
      rb  = real'(b);
      m   = $sqrt(ra * ra + rb * rb) * mag_scale;
      q   = longint'($atan2(rb, ra) / TWO_PI * 4294967296.0);
      ang = q[31:0];
   endfunction

   // Caller is at a falling edge; returns at the falling edge where done is seen (or after a bound).
   task automatic run_op(input logic signed [31:0] a, input logic signed [31:0] b,
                         output int lat, output int busy_cnt);
      bus.re    = a;
      bus.im    = b;
      bus.start = 1'b1;
      busy_cnt  = 0;
      @(negedge clock);
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 200) begin
         if (bus.busy) busy_cnt++;
         @(negedge clock);
         lat++;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.re    = '0;
      bus.im    = '0;
      repeat (3) @(negedge clock);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
      n_checks++; if (bus.mag !== 34'd0) begin n_fail++; $display("FAIL reset_mag: got %0h expected 0", bus.mag); end
      n_checks++; if (bus.angle !== 32'd0) begin n_fail++; $display("FAIL reset_angle: got %0h expected 0", bus.angle); end
      n_checks++; if (bus.polar !== 66'd0) begin n_fail++; $display("FAIL reset_polar: got %0h expected 0", bus.polar); end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_directed();
      logic signed [31:0] t_re [9] = '{32'sd1000000, 32'sd0, -32'sd1000000, 32'sd3000000, 32'sh8000_0000,
                                       32'sh8000_0000, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'sd65536};
      logic signed [31:0] t_im [9] = '{32'sd0, -32'sd1000000, 32'sd1000000, 32'sd4000000, 32'sh8000_0000,
                                       32'sd0, 32'sh7FFF_FFFF, 32'sh8000_0000, -32'sd3};
      int          lat;
      int          bcnt;
      real         em;
      real         md;
      logic [31:0] ea;
      logic [31:0] da;
      int          sd;
      for (int i = 0; i < 9; i++) begin
         run_op(t_re[i], t_im[i], lat, bcnt);
         model(t_re[i], t_im[i], em, ea);
         n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, LAT); end
         n_checks++; if (bcnt !== LAT - 1) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bcnt, LAT - 1); end
         n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done: got %0b expected 0", i, bus.busy); end
         da = bus.angle - ea;
         sd = int'($signed(da));
         n_checks++; if (sd > ANG_TOL || sd < -ANG_TOL) begin n_fail++; $display("FAIL dir%0d_angle: got %08h expected %08h +/-%0d", i, bus.angle, ea, ANG_TOL); end
         md = real'({30'b0, bus.mag}) - em;
         n_checks++; if (md > MAG_TOL || md < -MAG_TOL) begin n_fail++; $display("FAIL dir%0d_mag: got %0d expected %0.2f +/-4", i, bus.mag, em); end
         n_checks++; if (bus.polar !== {bus.mag, bus.angle}) begin n_fail++; $display("FAIL dir%0d_polar: got %0h expected %0h", i, bus.polar, {bus.mag, bus.angle}); end
      end
   endtask

   task automatic test_random();
      logic signed [31:0] a;
      logic signed [31:0] b;
      int          lat;
      int          bcnt;
      real         em;
      real         md;
      logic [31:0] ea;
      logic [31:0] da;
      int          sd;
      for (int i = 0; i < 24; i++) begin
         a = $signed($urandom) >>> $urandom_range(0, 14);
         b = $signed($urandom) >>> $urandom_range(0, 14);
         if (a < 65536 && a > -65536 && b < 65536 && b > -65536) a = 32'sh0012_3456;
         run_op(a, b, lat, bcnt);
         model(a, b, em, ea);
         n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, LAT); end
         da = bus.angle - ea;
         sd = int'($signed(da));
         n_checks++; if (sd > ANG_TOL || sd < -ANG_TOL) begin n_fail++; $display("FAIL rnd%0d_angle re=%0d im=%0d: got %08h expected %08h", i, a, b, bus.angle, ea); end
         md = real'({30'b0, bus.mag}) - em;
         n_checks++; if (md > MAG_TOL || md < -MAG_TOL) begin n_fail++; $display("FAIL rnd%0d_mag re=%0d im=%0d: got %0d expected %0.2f", i, a, b, bus.mag, em); end
      end
   endtask

   task automatic test_zero();
      int lat;
      int bcnt;
      run_op(32'sd0, 32'sd0, lat, bcnt);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
      n_checks++; if (bus.mag !== 34'd0) begin n_fail++; $display("FAIL zero_mag: got %0h expected 0", bus.mag); end
      n_checks++; if (bus.angle !== 32'd0) begin n_fail++; $display("FAIL zero_angle: got %0h expected 0", bus.angle); end
      n_checks++; if (bus.polar !== 66'd0) begin n_fail++; $display("FAIL zero_polar: got %0h expected 0", bus.polar); end
   endtask

   task automatic test_start_while_busy();
      int          dones = 0;
      int          done_at = -1;
      real         em;
      real         md;
      logic [31:0] ea;
      logic [31:0] da;
      int          sd;
      bus.re    = 32'sd2500000;
      bus.im    = -32'sd1500000;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      for (int k = 0; k < LAT + 12; k++) begin
         if (k >= 3 && k <= 6) begin
            bus.re    = -32'sd7000000;
            bus.im    = 32'sd9000000;
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            dones++;
            if (done_at < 0) done_at = k;
            model(32'sd2500000, -32'sd1500000, em, ea);
            da = bus.angle - ea;
            sd = int'($signed(da));
            n_checks++; if (sd > ANG_TOL || sd < -ANG_TOL) begin n_fail++; $display("FAIL busy_ignore_angle: got %08h expected %08h", bus.angle, ea); end
            md = real'({30'b0, bus.mag}) - em;
            n_checks++; if (md > MAG_TOL || md < -MAG_TOL) begin n_fail++; $display("FAIL busy_ignore_mag: got %0d expected %0.2f", bus.mag, em); end
         end
         @(negedge clock);
      end
      bus.start = 1'b0;
      n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL busy_ignore_done_count: got %0d expected 1", dones); end
      n_checks++; if (done_at !== LAT) begin n_fail++; $display("FAIL busy_ignore_done_cycle: got %0d expected %0d", done_at, LAT); end
   endtask

   task automatic test_back_to_back();
      int          lat;
      int          bcnt;
      real         em;
      real         md;
      logic [31:0] ea;
      logic [31:0] da;
      logic [33:0] hold_mag;
      logic [31:0] hold_ang;
      int          sd;
      run_op(32'sd123456789, 32'sd98765432, lat, bcnt);
      run_op(-32'sd40000000, -32'sd300000, lat, bcnt);
      model(-32'sd40000000, -32'sd300000, em, ea);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
      da = bus.angle - ea;
      sd = int'($signed(da));
      n_checks++; if (sd > ANG_TOL || sd < -ANG_TOL) begin n_fail++; $display("FAIL b2b_angle: got %08h expected %08h", bus.angle, ea); end
      md = real'({30'b0, bus.mag}) - em;
      n_checks++; if (md > MAG_TOL || md < -MAG_TOL) begin n_fail++; $display("FAIL b2b_mag: got %0d expected %0.2f", bus.mag, em); end
      hold_mag = bus.mag;
      hold_ang = bus.angle;
      @(negedge clock);
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %0b expected 0", bus.done); end
      repeat (4) @(negedge clock);
      n_checks++; if (bus.mag !== hold_mag) begin n_fail++; $display("FAIL hold_mag: got %0h expected %0h", bus.mag, hold_mag); end
      n_checks++; if (bus.angle !== hold_ang) begin n_fail++; $display("FAIL hold_angle: got %0h expected %0h", bus.angle, hold_ang); end
   endtask

   task automatic test_reset_mid();
      int          lat;
      int          bcnt;
      int          dones = 0;
      real         em;
      real         md;
      logic [31:0] ea;
      logic [31:0] da;
      int          sd;
      bus.re    = 32'sd2000000;
      bus.im    = -32'sd700000;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (10) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %0b expected 0", bus.busy); end
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %0b expected 0", bus.done); end
      n_checks++; if (bus.mag !== 34'd0) begin n_fail++; $display("FAIL midreset_mag: got %0h expected 0", bus.mag); end
      n_checks++; if (bus.angle !== 32'd0) begin n_fail++; $display("FAIL midreset_angle: got %0h expected 0", bus.angle); end
      reset = 1'b0;
      for (int k = 0; k < LAT + 5; k++) begin
         if (bus.done) dones++;
         @(negedge clock);
      end
      n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midreset_stray_done: got %0d expected 0", dones); end
      run_op(-32'sd5000000, 32'sd123456, lat, bcnt);
      model(-32'sd5000000, 32'sd123456, em, ea);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL postreset_latency: got %0d expected %0d", lat, LAT); end
      da = bus.angle - ea;
      sd = int'($signed(da));
      n_checks++; if (sd > ANG_TOL || sd < -ANG_TOL) begin n_fail++; $display("FAIL postreset_angle: got %08h expected %08h", bus.angle, ea); end
      md = real'({30'b0, bus.mag}) - em;
      n_checks++; if (md > MAG_TOL || md < -MAG_TOL) begin n_fail++; $display("FAIL postreset_mag: got %0d expected %0.2f", bus.mag, em); end
   endtask

   initial begin
      real p;
      mag_scale = 1.0;
`ifndef CORDIC_GAIN_COMP_EN
      p = 1.0;
      for (int i = 0; i < ITER; i++) begin
         mag_scale = mag_scale * $sqrt(1.0 + p);
         p = p * 0.25;
      end
`endif
      @(negedge clock);
      test_reset();
      test_directed();
      test_random();
      test_zero();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog expired");
   end
endmodule
